// File: rtl/corelet_pkg.sv
// Shared corelet types and default geometry.
// Used by the SRAM->L0 producer and its write skid.
package corelet_pkg;

    localparam int BW       = 4;
    localparam int ROW      = 8;
    localparam int COL      = 8;
    localparam int L0_W     = ROW * BW;
    localparam int LEN_ONIJ = 16;
    localparam int LEN_KIJ  = 9;
    localparam int ADDR_W   = 11;
    localparam int W_BASE   = 0;
    localparam int X_BASE   = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_XLOAD,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/l0_wr_skid.sv
// One-entry hold register between SRAM read data and the L0 write port.
// Passes returning data straight through when empty.
module l0_wr_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         hold_v
);

    logic [W-1:0] hold_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_v <= 1'b0;
            hold_q <= '0;
        end else if (hold_v) begin
            if (ready) hold_v <= 1'b0;
        end else if (in_valid && !ready) begin
            hold_v <= 1'b1;
            hold_q <= in_data;
        end
    end

    assign out_valid = hold_v | in_valid;
    assign out_data  = hold_v   ? hold_q  :
                       in_valid ? in_data : '0;

endmodule

// File: rtl/sram_to_l0_fsm.sv
// Producer side of the L0 input FIFO: per kij, streams col weight words
// then len_onij activation words from SRAM into L0.
module sram_to_l0_fsm
    import corelet_pkg::*;
#(
    parameter int bw         = BW,
    parameter int row        = ROW,
    parameter int col        = COL,
    parameter int addr_width = ADDR_W,
    parameter int len_onij   = LEN_ONIJ,
    parameter int len_kij    = LEN_KIJ,
    parameter int w_base     = W_BASE,
    parameter int x_base     = X_BASE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  l0_wr_ready_i,
    output logic                  sram_rd_en_o,
    output logic [addr_width-1:0] sram_addr_o,
    input  logic [row*bw-1:0]     sram_data_i,
    output logic                  l0_wr_en_o,
    output logic [row*bw-1:0]     l0_wr_data_o,
    output logic [3:0]            kij_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int WORD_W = row * bw;
    localparam int CW     = (col > 1) ? $clog2(col) : 1;
    localparam int XW     = (len_onij > 1) ? $clog2(len_onij) : 1;

    localparam logic [CW-1:0] W_LAST = CW'(col - 1);
    localparam logic [XW-1:0] X_LAST = XW'(len_onij - 1);
    localparam logic [3:0]    K_LAST = 4'(len_kij - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [XW-1:0]   xcnt_q, xcnt_d;
    logic [3:0]      kij_q, kij_d;
    logic            rd_vld_q;
    logic            hold_v;
    logic            can_issue;
    logic            rd_en;
    logic [addr_width-1:0] w_addr, x_addr;

    assign w_addr = addr_width'(w_base)
                  + addr_width'(kij_q) * addr_width'(col)
                  + addr_width'(wcnt_q);
    assign x_addr = addr_width'(x_base)
                  + addr_width'(kij_q) * addr_width'(len_onij)
                  + addr_width'(xcnt_q);

    // A return that misses ready fills the hold next cycle; don't issue into it.
    assign can_issue = !hold_v && !(rd_vld_q && !l0_wr_ready_i);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            xcnt_q   <= '0;
            kij_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            xcnt_q   <= xcnt_d;
            kij_q    <= kij_d;
            rd_vld_q <= rd_en;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        xcnt_d      = xcnt_q;
        kij_d       = kij_q;
        rd_en       = 1'b0;
        sram_addr_o = '0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_WLOAD;
            end
            S_WLOAD: begin
                busy_o      = 1'b1;
                sram_addr_o = w_addr;
                rd_en       = can_issue;
                if (can_issue) begin
                    if (wcnt_q == W_LAST) begin
                        wcnt_d  = '0;
                        state_d = S_XLOAD;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            S_XLOAD: begin
                busy_o      = 1'b1;
                sram_addr_o = x_addr;
                rd_en       = can_issue;
                if (can_issue && xcnt_q == X_LAST) begin
                    xcnt_d = '0;
                    if (kij_q == K_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        kij_d   = kij_q + 1'b1;
                        state_d = S_WLOAD;
                    end
                end else if (can_issue) begin
                    xcnt_d = xcnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                // Leave once the last word is being accepted this cycle.
                if (!hold_v && (!rd_vld_q || l0_wr_ready_i))
                    state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                kij_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sram_rd_en_o = rd_en;
    assign kij_o        = kij_q;

    l0_wr_skid #(
        .W(WORD_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (rd_vld_q),
        .in_data  (sram_data_i),
        .ready    (l0_wr_ready_i),
        .out_valid(l0_wr_en_o),
        .out_data (l0_wr_data_o),
        .hold_v   (hold_v)
    );

endmodule

// File: tb/tb_sram_to_l0_fsm.sv
// Randomized bench for sram_to_l0_fsm: SRAM model, expected write
// stream built from the kij/weight/activation ordering rules.
module tb_sram_to_l0_fsm;

    localparam int COL      = 8;
    localparam int LEN_ONIJ = 16;
    localparam int LEN_KIJ  = 9;
    localparam int W_BASE   = 0;
    localparam int X_BASE   = 1024;
    localparam int TOT      = LEN_KIJ * (COL + LEN_ONIJ);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic        l0_wr_ready_i = 1'b1;
    logic        sram_rd_en_o;
    logic [10:0] sram_addr_o;
    logic [31:0] sram_data_i = '0;
    logic        l0_wr_en_o;
    logic [31:0] l0_wr_data_o;
    logic [3:0]  kij_o;
    logic        busy_o;
    logic        done_o;

    sram_to_l0_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .l0_wr_ready_i(l0_wr_ready_i),
        .sram_rd_en_o (sram_rd_en_o),
        .sram_addr_o  (sram_addr_o),
        .sram_data_i  (sram_data_i),
        .l0_wr_en_o   (l0_wr_en_o),
        .l0_wr_data_o (l0_wr_data_o),
        .kij_o        (kij_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:2047];
    logic [31:0] exp_q [0:TOT-1];

    always @(posedge clk)
        sram_data_i <= sram_rd_en_o ? mem[sram_addr_o] : $urandom;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          mode = 0;
    int          stall_left = 0;
    int          wr_idx = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          done_cyc = 0;
    bit          first_rd_seen = 0;
    logic [10:0] first_rd_addr = '0;
    logic [31:0] first_data = '0;
    logic [31:0] ninth_data = '0;

    // Drives ready each negedge, then scores the cycle 1 unit later.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            case (mode)
                1, 3: begin
                    if (l0_wr_en_o && stall_left > 0 &&
                        wr_idx == ((mode == 1) ? 4 : COL + LEN_ONIJ - 1)) begin
                        l0_wr_ready_i = 1'b0;
                        stall_left--;
                        chk("held_word", l0_wr_data_o, exp_q[wr_idx]);
                    end else begin
                        l0_wr_ready_i = 1'b1;
                    end
                end
                2: l0_wr_ready_i = ~l0_wr_ready_i;
                4: l0_wr_ready_i = ($urandom_range(0, 3) != 0);
                default: l0_wr_ready_i = 1'b1;
            endcase
            #1;
            if (sram_rd_en_o && !first_rd_seen) begin
                first_rd_seen = 1;
                first_rd_addr = sram_addr_o;
            end
            if (l0_wr_en_o && l0_wr_ready_i) begin
                if (wr_idx < TOT)
                    chk("wr_data", l0_wr_data_o, exp_q[wr_idx]);
                else
                    chk("extra_wr", wr_idx, TOT - 1);
                if (mode == 3 && wr_idx == COL + LEN_ONIJ)
                    chk("kij_bnd", kij_o, 1);
                if (wr_idx == 0) begin
                    first_cyc  = cyc;
                    first_data = l0_wr_data_o;
                end
                if (wr_idx == COL) ninth_data = l0_wr_data_o;
                last_cyc = cyc;
                wr_idx++;
            end
            if (done_o) begin
                chk("busy_in_done", busy_o, 0);
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #2 start_i = 1'b1;
        @(posedge clk);
        #2 start_i = 1'b0;
    endtask

    task automatic arm(input int m);
        mode          = m;
        wr_idx        = 0;
        done_cnt      = 0;
        first_rd_seen = 0;
        stall_left    = (m == 1) ? 3 : (m == 3) ? 2 : 0;
    endtask

    task automatic run_one(input int m, input bit extra);
        bit fin;
        arm(m);
        pulse_start();
        chk("busy_after_start", busy_o, 1);
        fin = 0;
        for (int i = 0; i < 4000 && !fin; i++) begin
            @(negedge clk);
            #2;
            if (extra && (i == 50 || done_o)) start_i = 1'b1;
            else start_i = 1'b0;
            if (done_cnt > 0) fin = 1;
        end
        @(posedge clk);
        #2 start_i = 1'b0;
        chk("run_timeout", fin, 1);
        repeat (10) @(negedge clk);
        #2;
        chk("wr_count", wr_idx, TOT);
        chk("done_pulses", done_cnt, 1);
        chk("busy_idle", busy_o, 0);
        chk("first_rd_addr", first_rd_addr, W_BASE);
        if (m == 0) begin
            chk("first_wr", first_data, mem[W_BASE]);
            chk("ninth_wr", ninth_data, mem[X_BASE]);
            chk("stream_cycles", last_cyc - first_cyc + 1, TOT);
            chk("done_timing", done_cyc, last_cyc + 1);
        end
    endtask

    initial begin
        int idx;
        bit found;
        int n;
        for (int a = 0; a < 2048; a++) mem[a] = $urandom;
        idx = 0;
        for (int k = 0; k < LEN_KIJ; k++) begin
            for (int w = 0; w < COL; w++)
                exp_q[idx++] = mem[W_BASE + k * COL + w];
            for (int x = 0; x < LEN_ONIJ; x++)
                exp_q[idx++] = mem[X_BASE + k * LEN_ONIJ + x];
        end

        #3;
        chk("reset_outs",
            {sram_rd_en_o, sram_addr_o, l0_wr_en_o, l0_wr_data_o,
             kij_o, busy_o, done_o}, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;

        run_one(0, 0);
        run_one(1, 0);
        run_one(2, 0);
        run_one(3, 0);

        arm(0);
        pulse_start();
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            #2;
            if (kij_o == 4 && sram_rd_en_o &&
                sram_addr_o >= 11'(X_BASE + 4 * LEN_ONIJ + 5))
                found = 1;
        end
        chk("reach_kij4_x", found, 1);
        reset = 1'b0;
        #1;
        chk("abort_outs",
            {sram_rd_en_o, sram_addr_o, l0_wr_en_o, l0_wr_data_o,
             kij_o, busy_o, done_o}, 0);
        n = wr_idx;
        repeat (3) @(negedge clk);
        #2;
        chk("no_wr_in_reset", wr_idx, n);
        reset = 1'b1;

        run_one(0, 0);
        run_one(4, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
